// File: rtl/press_event_decoder_pkg.sv
// Shared state encoding and default sizing for the push-button event decoder.
// Optional auto-repeat is enabled by defining PRESS_EVENT_AUTO_REPEAT_EN.
package press_event_decoder_pkg;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    PRESS = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_LONG_CNT   = 100;
  localparam int DEF_REPEAT_CNT = 25;

  function automatic logic isHeldState(input state_t s);
    return (s == PRESS) || (s == HOLD);
  endfunction

endpackage

// File: rtl/press_event_decoder_event_timer.sv
// Cycle counter with clear/enable and a terminal-count flag at TERM-1.
// Shared by the hold and repeat timers (repeat only with PRESS_EVENT_AUTO_REPEAT_EN).
module press_event_decoder_event_timer #(
  parameter int CNT_W = 8,
  parameter int TERM  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam logic [CNT_W-1:0] LastVal = CNT_W'(TERM - 1);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over enable so the owner can restart the count on the wrap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_o = (cnt_q == LastVal);

endmodule

// File: rtl/press_event_decoder.sv
// Turns a debounced button level into one-cycle short/long/repeat event pulses.
// Auto-repeat is built only when PRESS_EVENT_AUTO_REPEAT_EN is defined.
module press_event_decoder
  import press_event_decoder_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LONG_CNT   = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_level,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  state_t state_q, state_d;
  logic   shortPulse_q, shortPulse_d;
  logic   longPulse_q, longPulse_d;
  logic   held_q, held_d;
  logic   holdClr, holdEn, holdLast;

  press_event_decoder_event_timer #(
    .CNT_W (CNT_W),
    .TERM  (LONG_CNT)
  ) u_holdTimer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (holdClr),
    .en_i   (holdEn),
    .last_o (holdLast)
  );

  // ARM swallows a press already in progress at reset until the button is released.
  always_comb begin
    state_d      = state_q;
    shortPulse_d = 1'b0;
    longPulse_d  = 1'b0;
    holdClr      = 1'b0;
    holdEn       = 1'b0;
    case (state_q)
      ARM: begin
        holdClr = 1'b1;
        if (!pb_level) state_d = IDLE;
      end
      IDLE: begin
        if (pb_level) begin
          state_d = PRESS;
          holdEn  = 1'b1;
        end else begin
          holdClr = 1'b1;
        end
      end
      PRESS: begin
        if (pb_level) begin
          if (holdLast) begin
            state_d     = HOLD;
            longPulse_d = 1'b1;
          end else begin
            holdEn = 1'b1;
          end
        end else begin
          state_d      = IDLE;
          shortPulse_d = 1'b1;
          holdClr      = 1'b1;
        end
      end
      HOLD: begin
        if (!pb_level) begin
          state_d = IDLE;
          holdClr = 1'b1;
        end
      end
      default: begin
        state_d = ARM;
        holdClr = 1'b1;
      end
    endcase
    held_d = isHeldState(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARM;
      shortPulse_q <= 1'b0;
      longPulse_q  <= 1'b0;
      held_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shortPulse_q <= shortPulse_d;
      longPulse_q  <= longPulse_d;
      held_q       <= held_d;
    end
  end

`ifdef PRESS_EVENT_AUTO_REPEAT_EN
  logic repStep, repLast;
  logic repeatPulse_q, repeatPulse_d;

  // The repeat timer runs only while held in HOLD and restarts on every pulse.
  assign repStep       = (state_q == HOLD) && pb_level;
  assign repeatPulse_d = repStep && repLast;

  press_event_decoder_event_timer #(
    .CNT_W (CNT_W),
    .TERM  (REPEAT_CNT)
  ) u_repTimer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!repStep || repLast),
    .en_i   (repStep),
    .last_o (repLast)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repeatPulse_q <= 1'b0;
    end else begin
      repeatPulse_q <= repeatPulse_d;
    end
  end

  assign repeat_pulse = repeatPulse_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign short_pulse = shortPulse_q;
  assign long_pulse  = longPulse_q;
  assign held        = held_q;

endmodule

// File: doc/press_event_decoder.md
Name: press_event_decoder

Overview:
- Consumes the active-high debounced push-button level and classifies it into one-cycle event pulses: short press, long press, and optional auto-repeat.
- Sits downstream of the button debouncer and upstream of control FSMs (counters, mode selectors) that need single-cycle commands instead of a held level.
- Runs on the same clock as the debouncer.

Parameters:
- CNT_W, 8, width of the hold and repeat cycle counters.
- LONG_CNT, 100, number of held cycles that makes a press "long". Must satisfy 2 <= LONG_CNT <= 2^CNT_W-1.
- REPEAT_CNT, 25, cycles between auto-repeat pulses while in HOLD. Must satisfy 1 <= REPEAT_CNT <= 2^CNT_W-1.

Ports:
- clk  input  1  system clock; pb_level is synchronous to it.
- rst  input  1  asynchronous, active-high reset.
- pb_level  input  1  debounced button level; 1 = pressed.
- short_pulse  output  1  one-cycle pulse on release of a press held for fewer than LONG_CNT cycles.
- long_pulse  output  1  one-cycle pulse when a press reaches LONG_CNT cycles.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CNT cycles in HOLD. Only driven when AUTO_REPEAT_EN is defined.
- held  output  1  high while state is PRESS or HOLD.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- All outputs are registered.
- Reset values:
  - all pulses = 0, held = 0
  - hold_cnt = 0, rep_cnt = 0
  - state = ARM
- States: ARM, IDLE, PRESS, HOLD. pb_level is evaluated at each rising clk edge.
- ARM:
  - Stays in ARM while pb_level = 1.
  - pb_level = 0 -> IDLE.
  - Purpose: a button held through reset never produces a phantom event.
- IDLE:
  - pb_level = 1 -> PRESS, hold_cnt = 1, held = 1 from that edge.
- PRESS, pb_level = 1:
  - If hold_cnt + 1 == LONG_CNT: go to HOLD, long_pulse = 1 for one cycle, rep_cnt = 0.
  - Otherwise: hold_cnt increments.
- PRESS, pb_level = 0:
  - Go to IDLE, short_pulse = 1 for one cycle, held = 0, hold_cnt = 0.
- HOLD, pb_level = 1:
  - With the macro: rep_cnt increments. When rep_cnt + 1 == REPEAT_CNT, repeat_pulse = 1 for one cycle and rep_cnt returns to 0.
  - The first repeat arrives REPEAT_CNT cycles after long_pulse.
- HOLD, pb_level = 0:
  - Go to IDLE, held = 0, counters clear.
  - No short_pulse is produced after a long press.
- Mutual exclusion: at most one of short_pulse, long_pulse, repeat_pulse is high in any cycle.
- Latency:
  - short_pulse is high in the cycle after the first low sample.
  - long_pulse is high in the cycle after the LONG_CNT-th consecutive high sample (counted from the IDLE->PRESS edge).
- Minimum press: a single high sample then low gives hold_cnt = 1 and produces short_pulse.
- Counters never wrap: hold_cnt <= LONG_CNT-1 and rep_cnt <= REPEAT_CNT-1 by construction.
- Reset asserted mid-press: outputs clear immediately (asynchronous), FSM returns to ARM, and no event is emitted for the interrupted press.
- Unreachable state encodings decode to ARM.

Optional Feature:
- Macro: PRESS_EVENT_AUTO_REPEAT_EN.
- Defined: the rep_cnt logic and repeat_pulse generation are present as described above.
- Undefined:
  - rep_cnt is not instantiated.
  - repeat_pulse is tied to 0.
  - HOLD only waits for release.
  - short_pulse and long_pulse behaviour is identical in both builds.

Decomposition:
- global.v holds:
  - state encodings (ARM = 2'd0, IDLE = 2'd1, PRESS = 2'd2, HOLD = 2'd3)
  - default CNT_W, LONG_CNT and REPEAT_CNT defines
  - PRESS_EVENT_AUTO_REPEAT_EN
- One natural sub-module, event_timer:
  - a CNT_W-bit counter with clear and enable inputs and a terminal-count compare against a parameter
  - instantiated once for hold_cnt and once (under the macro) for rep_cnt.

Test Plan (LONG_CNT=8, REPEAT_CNT=4, macro defined unless stated):
- Hold pb_level=1 through reset deassertion for 20 cycles, then low -> no pulses, held stays 0; the next press is decoded normally.
- Press for 3 cycles, then release -> exactly one short_pulse, in the cycle after the first low sample; long_pulse stays 0; held is high for 3 cycles.
- Press for 7 cycles -> short_pulse. Press for 8 cycles -> long_pulse on the 8th cycle, no short_pulse on release (boundary check).
- Hold for 20 cycles -> long_pulse at cycle 8, then repeat_pulse at cycles 12, 16 and 20; no pulses after release.
- Same stimulus with the macro undefined -> long_pulse at cycle 8, repeat_pulse never asserts.
- Assert rst at cycle 5 of a press while pb_level stays high -> all outputs 0 immediately; after reset no pulse until a low sample then a new press.
